bitstream_decoder: RTL and testbench

Serial receive-side counterpart of the packet bitstream encoder. It samples one bit per qualified clock and reassembles PID, address, endpoint and data fields into parallel registers. It checks the PID and the packet length, then reports the packet with a one-cycle `pktvalid` or `pkterr` pulse. It sits between the serial link and the protocol controller, which consumes the decoded fields.

---
 rtl/bitstream_decoder.sv | 183 ++++++++++++++++++
 tb/tb_bitstream_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_decoder.sv
// Serial packet decoder: shifts LSB-first PID/ADDR/ENDP/DATA fields in on each
// qualified bit, validates PID and length, and publishes fields on good packets.
module bitstream_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        inb,
  input  logic        receiving,
  input  logic        pause,
  output logic [3:0]  pid,
  output logic [6:0]  addr,
  output logic [3:0]  endp,
  output logic [63:0] data,
  output logic        pktvalid,
  output logic        pkterr,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_PID, S_ADDR, S_ENDP, S_DATA, S_WAIT} state_e;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [7:0]  pid_sr_q, pid_sr_d;
  logic [6:0]  addr_sr_q, addr_sr_d;
  logic [3:0]  endp_sr_q, endp_sr_d;
  logic [63:0] data_sr_q, data_sr_d;
  logic [3:0]  pid_q, pid_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  endp_q, endp_d;
  logic [63:0] data_q, data_d;
  logic        pktvalid_q, pktvalid_d;
  logic        pkterr_q, pkterr_d;

  logic        bit_en;
  logic [7:0]  pid_shift;
  logic [6:0]  addr_shift;
  logic [3:0]  endp_shift;
  logic [63:0] data_shift;
  logic        pid_ok;

  // Fields arrive LSB first, so new bits enter at the MSB and walk down.
  assign bit_en     = receiving & ~pause;
  assign pid_shift  = {inb, pid_sr_q[7:1]};
  assign addr_shift = {inb, addr_sr_q[6:1]};
  assign endp_shift = {inb, endp_sr_q[3:1]};
  assign data_shift = {inb, data_sr_q[63:1]};
  assign pid_ok     = (pid_shift[7:4] == ~pid_shift[3:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pid_sr_q   <= '0;
      addr_sr_q  <= '0;
      endp_sr_q  <= '0;
      data_sr_q  <= '0;
      pid_q      <= '0;
      addr_q     <= '0;
      endp_q     <= '0;
      data_q     <= '0;
      pktvalid_q <= 1'b0;
      pkterr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pid_sr_q   <= pid_sr_d;
      addr_sr_q  <= addr_sr_d;
      endp_sr_q  <= endp_sr_d;
      data_sr_q  <= data_sr_d;
      pid_q      <= pid_d;
      addr_q     <= addr_d;
      endp_q     <= endp_d;
      data_q     <= data_d;
      pktvalid_q <= pktvalid_d;
      pkterr_q   <= pkterr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pid_sr_d   = pid_sr_q;
    addr_sr_d  = addr_sr_q;
    endp_sr_d  = endp_sr_q;
    data_sr_d  = data_sr_q;
    pid_d      = pid_q;
    addr_d     = addr_q;
    endp_d     = endp_q;
    data_d     = data_q;
    pktvalid_d = 1'b0;
    pkterr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bit_en) begin
          state_d  = S_PID;
          cnt_d    = 7'd1;
          pid_sr_d = pid_shift;
        end
      end
      S_PID, S_ADDR, S_ENDP, S_DATA: begin
        // Link dropped mid-packet: abandon whatever was shifted so far.
        if (!receiving) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          pkterr_d = 1'b1;
        end else if (bit_en) begin
          cnt_d = cnt_q + 7'd1;
          case (state_q)
            S_PID: begin
              pid_sr_d = pid_shift;
              if (cnt_q == 7'd7) begin
                cnt_d   = '0;
                state_d = S_WAIT;
                if (!pid_ok) begin
                  pkterr_d = 1'b1;
                end else begin
                  case (pid_shift[3:0])
                    PID_OUT, PID_IN: state_d = S_ADDR;
                    PID_DATA0:       state_d = S_DATA;
                    PID_ACK, PID_NAK: begin
                      pktvalid_d = 1'b1;
                      pid_d      = pid_shift[3:0];
                    end
                    default:         pkterr_d = 1'b1;
                  endcase
                end
              end
            end
            S_ADDR: begin
              addr_sr_d = addr_shift;
              if (cnt_q == 7'd6) begin
                cnt_d   = '0;
                state_d = S_ENDP;
              end
            end
            S_ENDP: begin
              endp_sr_d = endp_shift;
              if (cnt_q == 7'd3) begin
                cnt_d      = '0;
                state_d    = S_WAIT;
                pktvalid_d = 1'b1;
                pid_d      = pid_sr_q[3:0];
                addr_d     = addr_sr_q;
                endp_d     = endp_shift;
              end
            end
            default: begin
              data_sr_d = data_shift;
              if (cnt_q == 7'd63) begin
                cnt_d      = '0;
                state_d    = S_WAIT;
                pktvalid_d = 1'b1;
                pid_d      = pid_sr_q[3:0];
                data_d     = data_shift;
              end
            end
          endcase
        end
      end
      S_WAIT: begin
        if (!receiving) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE) && (state_q != S_WAIT);
  end

  assign pid      = pid_q;
  assign addr     = addr_q;
  assign endp     = endp_q;
  assign data     = data_q;
  assign pktvalid = pktvalid_q;
  assign pkterr   = pkterr_q;

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed bench for bitstream_decoder: a vector table of whole packets plus
// hand-written pause, truncation and mid-packet reset sequences.
module tb_bitstream_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        inb;
  logic        receiving;
  logic        pause;
  logic [3:0]  pid;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [63:0] data;
  logic        pktvalid;
  logic        pkterr;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int nv    = 0;
  int ne    = 0;

  bitstream_decoder dut (
    .clk(clk), .rst(rst), .inb(inb), .receiving(receiving), .pause(pause),
    .pid(pid), .addr(addr), .endp(endp), .data(data),
    .pktvalid(pktvalid), .pkterr(pkterr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] bits;
    int          nbits;
    int          chk_at;
    logic        exp_v;
    logic        exp_e;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
  } vec_t;

  vec_t vt [8];

  function automatic logic [79:0] mk_pid(input logic [3:0] p, input logic [3:0] c);
    return {72'd0, c, p};
  endfunction

  function automatic logic [79:0] mk_tok(input logic [3:0] p, input logic [3:0] c,
                                         input logic [6:0] a, input logic [3:0] e);
    return {61'd0, e, a, c, p};
  endfunction

  function automatic logic [79:0] mk_dat(input logic [3:0] p, input logic [3:0] c,
                                         input logic [63:0] d);
    return {8'd0, d, c, p};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pktvalid === 1'b1) nv++;
    if (pkterr === 1'b1) ne++;
    chk("pulse_exclusive", {63'd0, pktvalid & pkterr}, 64'd0);
  endtask

  task automatic send_range(input logic [79:0] bits, input int lo, input int hi, input int maxp);
    for (int k = lo; k < hi; k++) begin
      if (maxp > 0 && k > lo) begin
        int np;
        np = $urandom_range(maxp, 1);
        for (int j = 0; j < np; j++) begin
          receiving = 1'b1;
          pause     = 1'b1;
          inb       = 1'($urandom);
          tick();
        end
      end
      receiving = 1'b1;
      pause     = 1'b0;
      inb       = bits[k];
      tick();
    end
  endtask

  task automatic idle_gap();
    receiving = 1'b0;
    pause     = 1'b0;
    inb       = 1'b0;
    tick();
  endtask

  task automatic chk_fields(input string tag, input logic [3:0] p, input logic [6:0] a,
                            input logic [3:0] e, input logic [63:0] d);
    chk({tag, "_pid"},  {60'd0, pid},  {60'd0, p});
    chk({tag, "_addr"}, {57'd0, addr}, {57'd0, a});
    chk({tag, "_endp"}, {60'd0, endp}, {60'd0, e});
    chk({tag, "_data"}, data, d);
  endtask

  initial begin
    int v0, e0;
    logic [79:0] b;

    vt[0] = '{mk_pid(4'h2, 4'hD), 8, 8, 1'b1, 1'b0, 4'h2, 7'h00, 4'h0, 64'h0};
    vt[1] = '{mk_tok(4'h1, 4'hE, 7'h5A, 4'h3), 19, 19, 1'b1, 1'b0, 4'h1, 7'h5A, 4'h3, 64'h0};
    vt[2] = '{mk_dat(4'h3, 4'hC, 64'hDEAD_BEEF_0000_1111), 72, 72, 1'b1, 1'b0,
              4'h3, 7'h5A, 4'h3, 64'hDEAD_BEEF_0000_1111};
    vt[3] = '{mk_tok(4'h1, 4'hF, 7'h7F, 4'hF), 11, 8, 1'b0, 1'b1,
              4'h3, 7'h5A, 4'h3, 64'hDEAD_BEEF_0000_1111};
    vt[4] = '{mk_tok(4'h9, 4'h6, 7'h01, 4'hF), 19, 19, 1'b1, 1'b0,
              4'h9, 7'h01, 4'hF, 64'hDEAD_BEEF_0000_1111};
    vt[5] = '{mk_pid(4'hA, 4'h5), 8, 8, 1'b1, 1'b0, 4'hA, 7'h01, 4'hF, 64'hDEAD_BEEF_0000_1111};
    vt[6] = '{mk_pid(4'h5, 4'hA), 8, 8, 1'b0, 1'b1, 4'hA, 7'h01, 4'hF, 64'hDEAD_BEEF_0000_1111};
    vt[7] = '{mk_tok(4'h9, 4'h0, 7'h11, 4'h2), 12, 8, 1'b0, 1'b1,
              4'hA, 7'h01, 4'hF, 64'hDEAD_BEEF_0000_1111};

    rst = 1'b1; receiving = 1'b0; pause = 1'b0; inb = 1'b0;
    tick();
    tick();
    chk_fields("reset", 4'h0, 7'h00, 4'h0, 64'h0);
    chk("reset_pktvalid", {63'd0, pktvalid}, 64'd0);
    chk("reset_pkterr", {63'd0, pkterr}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    idle_gap();

    for (int i = 0; i < 8; i++) begin
      v0 = nv; e0 = ne;
      send_range(vt[i].bits, 0, vt[i].chk_at, 0);
      chk($sformatf("vec%0d_pktvalid", i), {63'd0, pktvalid}, {63'd0, vt[i].exp_v});
      chk($sformatf("vec%0d_pkterr", i), {63'd0, pkterr}, {63'd0, vt[i].exp_e});
      chk_fields($sformatf("vec%0d", i), vt[i].pid, vt[i].addr, vt[i].endp, vt[i].data);
      send_range(vt[i].bits, vt[i].chk_at, vt[i].nbits, 0);
      idle_gap();
      chk($sformatf("vec%0d_idle_busy", i), {63'd0, busy}, 64'd0);
      chk($sformatf("vec%0d_nvalid", i), 64'(nv - v0), {63'd0, vt[i].exp_v});
      chk($sformatf("vec%0d_nerr", i), 64'(ne - e0), {63'd0, vt[i].exp_e});
      $display("vec%0d: pid=%h addr=%h endp=%h data=%h", i, pid, addr, endp, data);
    end

    // DATA0 with random pauses between bits
    v0 = nv; e0 = ne;
    send_range(mk_dat(4'h3, 4'hC, 64'h0123_4567_89AB_CDEF), 0, 72, 3);
    chk("paused_pktvalid", {63'd0, pktvalid}, 64'd1);
    chk_fields("paused", 4'h3, 7'h01, 4'hF, 64'h0123_4567_89AB_CDEF);
    idle_gap();
    chk("paused_nvalid", 64'(nv - v0), 64'd1);
    chk("paused_nerr", 64'(ne - e0), 64'd0);
    $display("paused data0: pid=%h data=%h", pid, data);

    // OUT token truncated after 12 bits, then a clean ACK
    send_range(mk_tok(4'h1, 4'hE, 7'h2B, 4'h6), 0, 12, 0);
    chk("trunc_busy", {63'd0, busy}, 64'd1);
    idle_gap();
    chk("trunc_pkterr", {63'd0, pkterr}, 64'd1);
    chk("trunc_pktvalid", {63'd0, pktvalid}, 64'd0);
    chk_fields("trunc", 4'h3, 7'h01, 4'hF, 64'h0123_4567_89AB_CDEF);
    chk("trunc_busy_after", {63'd0, busy}, 64'd0);
    send_range(mk_pid(4'h2, 4'hD), 0, 8, 0);
    chk("post_trunc_ack_valid", {63'd0, pktvalid}, 64'd1);
    chk("post_trunc_ack_pid", {60'd0, pid}, 64'h2);
    idle_gap();
    $display("truncation: pid=%h addr=%h endp=%h", pid, addr, endp);

    // NAK whose final bit coincides with receiving falling: truncated
    b = mk_pid(4'hA, 4'h5);
    send_range(b, 0, 7, 0);
    receiving = 1'b0;
    inb = b[7];
    tick();
    chk("lastbit_drop_pkterr", {63'd0, pkterr}, 64'd1);
    chk("lastbit_drop_pktvalid", {63'd0, pktvalid}, 64'd0);
    chk("lastbit_drop_pid", {60'd0, pid}, 64'h2);
    idle_gap();
    $display("last-bit drop: pkterr seen, pid=%h", pid);

    // Reset after PID + 30 data bits of a DATA0
    v0 = nv; e0 = ne;
    send_range(mk_dat(4'h3, 4'hC, 64'hFFFF_0000_FFFF_0000), 0, 38, 0);
    chk("midreset_busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    receiving = 1'b0;
    tick();
    chk_fields("midreset", 4'h0, 7'h00, 4'h0, 64'h0);
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    tick();
    chk("midreset_nvalid", 64'(nv - v0), 64'd0);
    chk("midreset_nerr", 64'(ne - e0), 64'd0);
    send_range(mk_tok(4'h1, 4'hE, 7'h5A, 4'h3), 0, 19, 0);
    chk("post_reset_valid", {63'd0, pktvalid}, 64'd1);
    chk_fields("post_reset", 4'h1, 7'h5A, 4'h3, 64'h0);
    idle_gap();
    $display("mid-packet reset: pid=%h addr=%h endp=%h data=%h", pid, addr, endp, data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
